mips_multicycle_ctrl: RTL and testbench

//  Moore FSM that sequences the MIPS datapath over several cycles, replacing the single-cycle control_unit.
//  One unified memory port is shared by instruction fetch and data access via iord.

---
 rtl/mips_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that steps the datapath through fetch, decode,
// execute, memory and write-back over several cycles. One memory port is shared by fetch and
// data access and selected with iord. Every memory state waits on the mem_ready handshake.
//
// Ports:
//   clk, rst_n             clock (rising edge) and synchronous active-low reset
//   op, funct              opcode and function fields from the instruction register
//   zero                   ALU zero flag, used by branches
//   mem_ready              memory completes this cycle
//   mem_req, iord          memory access request and address source (0 PC, 1 ALUOut)
//   mem_write, ir_write    one-cycle strobes, qualified by mem_ready
//   pc_en, pc_src          PC load enable and next-PC source
//   alu_src_a, alu_src_b   ALU operand selects
//   alucontrol             ALU operation
//   regdst, memtoreg       write-back destination and data selects
//   reg_write              register file write enable
//   illegal_op             one-cycle pulse after decoding an unsupported instruction
//   cycle_count            cycles since reset
//   instr_count            instructions retired
//
// Optional feature: define MC_BNE_EN to decode bne (op 000101) as a branch on ~zero.
// Without it, bne is treated as an illegal opcode.

module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alucontrol,
  output logic             regdst,
  output logic             memtoreg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExec, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic             illegal_q, illegal_d;
  logic             retire;

  // Ungated strobes; reset forces them low at the port.
  logic mem_req_c, mem_write_c, ir_write_c, reg_write_c;
  logic pc_write, branch, bne_take;

  // R-type function decode
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = 1'b0;
    retire      = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    bne_take    = 1'b0;
    iord        = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alucontrol  = 3'b010;
    regdst      = 1'b0;
    memtoreg    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'b01;
        // Strobes only on the completing cycle so a stall never repeats them.
        ir_write_c = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype: begin
            if (funct_ok) begin
              state_d = StExec;
            end else begin
              state_d   = StFetch;
              illegal_d = 1'b1;
            end
          end
          OpBeq:   state_d = StBranch;
`ifdef MC_BNE_EN
          OpBne:   state_d = StBranch;
`endif
          OpAddi:  state_d = StAddiEx;
          OpJ:     state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg    = 1'b1;
        reg_write_c = 1'b1;
        state_d     = StFetch;
        retire      = 1'b1;
      end
      StMemWr: begin
        mem_req_c   = 1'b1;
        iord        = 1'b1;
        mem_write_c = mem_ready;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec: begin
        alu_src_a  = 1'b1;
        alucontrol = funct_alu;
        state_d    = StAluWb;
      end
      StAluWb: begin
        regdst      = 1'b1;
        reg_write_c = 1'b1;
        state_d     = StFetch;
        retire      = 1'b1;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alucontrol = 3'b110;
        pc_src     = 2'b01;
`ifdef MC_BNE_EN
        // branch is kept for beq only so a bne with zero=1 does not take.
        if (op == OpBne) bne_take = ~zero;
        else             branch   = 1'b1;
`else
        branch = 1'b1;
`endif
        state_d = StFetch;
        retire  = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write_c = 1'b1;
        state_d     = StFetch;
        retire      = 1'b1;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cycle_q   <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_q + CNT_W'(1);
      illegal_q <= illegal_d;
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign mem_req     = rst_n & mem_req_c;
  assign mem_write   = rst_n & mem_write_c;
  assign ir_write    = rst_n & ir_write_c;
  assign reg_write   = rst_n & reg_write_c;
  assign pc_en       = rst_n & (pc_write | (branch & zero) | bne_take);
  assign illegal_op  = illegal_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: reset, R-type, stalled lw/sw, beq taken and not,
// illegal opcode, bne (build dependent), jump and a reset abandoning an instruction.

module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a;
  logic [2:0]  alucontrol;
  logic        regdst, memtoreg, reg_write, illegal_op;
  logic [31:0] cycle_count, instr_count;

  int passed = 0;
  int total  = 0;
  int c0, irw, mw, bad, exp_instr;

  logic rdy_lw [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic rdy_sw [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alucontrol  (alucontrol),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .reg_write   (reg_write),
    .illegal_op  (illegal_op),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    step();
    step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_instr", instr_count, 0);
    chk("rst_illegal", illegal_op, 0);

    // Release: first cycle is FETCH with mem_ready high
    rst_n = 1'b1; #1;
    chk("fetch_ir_write", ir_write, 1);
    chk("fetch_pc_en", pc_en, 1);
    chk("fetch_iord", iord, 0);
    chk("fetch_srcb", alu_src_b, 2'b01);
    chk("release_cycle", cycle_count, 0);

    // add: FETCH, DECODE, EXEC, ALUWB
    step();
    chk("dec_srcb", alu_src_b, 2'b11);
    chk("dec_ir_write", ir_write, 0);
    step();
    chk("exec_aluctl", alucontrol, 3'b010);
    chk("exec_srca", alu_src_a, 1);
    step();
    chk("aluwb_reg_write", reg_write, 1);
    chk("aluwb_regdst", regdst, 1);
    chk("aluwb_instr", instr_count, 0);
    step();
    chk("add_cycles", cycle_count, 4);
    chk("add_retire", instr_count, 1);
    chk("add_back_fetch", mem_req, 1);

    // lw: 3 FETCH stalls, 2 MEMRD stalls -> 10 cycles
    op = 6'b100011; c0 = int'(cycle_count); irw = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy_lw[i]; #1;
      irw += int'(ir_write);
      if (i == 7) chk("lw_memrd_stall", {29'd0, mem_req, iord, reg_write}, 3'b110);
      if (i == 9) chk("lw_memwb", {29'd0, memtoreg, reg_write, regdst}, 3'b110);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("lw_cycles", cycle_count - c0, 10);
    chk("lw_ir_pulses", irw, 1);
    chk("lw_retire", instr_count, 2);

    // sw: MEMWR stalls 4 cycles
    op = 6'b101011; c0 = int'(cycle_count); mw = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy_sw[i]; #1;
      mw += int'(mem_write);
      if (i >= 3 && mem_write !== mem_ready) bad++;
      step();
    end
    mem_ready = 1'b1; #1;
    chk("sw_write_cycles", mw, 1);
    chk("sw_write_align", bad, 0);
    chk("sw_cycles", cycle_count - c0, 8);
    chk("sw_retire", instr_count, 3);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    step();
    step();
    chk("beq_t_pc_en", pc_en, 1);
    chk("beq_t_pc_src", pc_src, 2'b01);
    chk("beq_aluctl", alucontrol, 3'b110);
    step();
    chk("beq_t_retire", instr_count, 4);
    zero = 1'b0;
    step();
    step();
    chk("beq_nt_pc_en", pc_en, 0);
    step();
    chk("beq_nt_retire", instr_count, 5);

    // Illegal opcode
    op = 6'b111111;
    step();
    chk("ill_dec_pulse", illegal_op, 0);
    step();
    chk("ill_pulse", illegal_op, 1);
    chk("ill_fetch", mem_req, 1);
    chk("ill_no_retire", instr_count, 5);
    exp_instr = 5;

    // bne with zero=0
    op = 6'b000101;
    step();
    chk("ill_pulse_end", illegal_op, 0);
    step();
`ifdef MC_BNE_EN
    chk("bne_pc_en", pc_en, 1);
    chk("bne_legal", illegal_op, 0);
    step();
    exp_instr = 6;
`else
    chk("bne_illegal", illegal_op, 1);
    chk("bne_fetch", mem_req, 1);
`endif
    chk("bne_instr", instr_count, exp_instr);

    // j: 3 cycles
    op = 6'b000010;
    step();
    step();
    chk("j_pc_en", pc_en, 1);
    chk("j_pc_src", pc_src, 2'b10);
    step();
    chk("j_retire", instr_count, exp_instr + 1);

    // sub abandoned by reset during ALUWB
    op = 6'b000000; funct = 6'b100010;
    step();
    step();
    chk("sub_aluctl", alucontrol, 3'b110);
    step();
    chk("sub_reg_write", reg_write, 1);
    rst_n = 1'b0; #1;
    chk("rst_forces_reg_write", reg_write, 0);
    step();
    chk("midrst_cycle", cycle_count, 0);
    chk("midrst_instr", instr_count, 0);
    chk("midrst_mem_req", mem_req, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_cycle", cycle_count, 1);
    chk("post_rst_decode", alu_src_b, 2'b11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
